// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with one-entry byte buffer, overrun and framing-error flags
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 10408,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [13:0] CNT_FULL = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] CNT_HALF = 14'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_pipe;
    logic        rst_n;
    logic        sync1, rxs;
    logic [13:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        load, ferr_nxt;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != 14'd0) ? cnt - 14'd1 : cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        load        = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            START: begin
                if (cnt == 14'd0) begin
                    if (!rxs) begin
                        state_nxt   = DATA;
                        cnt_nxt     = CNT_FULL;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == 14'd0) begin
                    shreg_nxt   = {rxs, shreg[7:1]};
                    cnt_nxt     = CNT_FULL;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == 14'd0) begin
                    if (rxs) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BRK;
                    end
                end
            end
            BRK: begin
                // A held-low line must go high before another start bit counts.
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 14'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            frame_err <= ferr_nxt;
            if (load) begin
                // A simultaneous ack retires the old byte, so the new one is not an overrun.
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                overrun  <= rx_ack ? 1'b0 : (overrun | rx_valid);
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - randomized self-checking bench for uart_rx_byte
module tb_uart_rx_byte;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_rises = 0;
    int rise_cyc = 0;
    int ferr_cycles = 0;
    logic prev_valid = 1'b0;
    int meas_lat = 155;

    logic [7:0] exp_data;
    logic       exp_valid, exp_ov;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_rises <= valid_rises + 1;
            rise_cyc    <= cyc;
        end
        prev_valid <= rx_valid;
        if (frame_err) ferr_cycles <= ferr_cycles + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (C) tick();
        end
        rxd = stop;
        repeat (C) tick();
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ov    = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b1;
        repeat (4) tick();
        exp_data = 8'h00; exp_valid = 1'b0; exp_ov = 1'b0;
    endtask

    task automatic test_fixed_frame();
        int v0, f0, t0, lat;
        v0 = valid_rises; f0 = ferr_cycles; t0 = cyc;
        send_frame(8'h55, 1'b1);
        rxd = 1'b1;
        tick();
        lat = rise_cyc - t0;
        meas_lat = lat;
        checks++; if (valid_rises !== v0 + 1) begin errors++; $display("FAIL fixed_rises got %0d want %0d", valid_rises, v0 + 1); end
        checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL fixed_data got %h want 55", rx_data); end
        checks++; if (lat < 153 || lat > 155) begin errors++; $display("FAIL fixed_latency got %0d want 153..155", lat); end
        checks++; if (ferr_cycles !== f0) begin errors++; $display("FAIL fixed_ferr got %0d want %0d", ferr_cycles, f0); end
        exp_data = 8'h55; exp_valid = 1'b1;
        do_ack();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fixed_ack_valid got %b want 0", rx_valid); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1);
            rxd = 1'b1;
            if (exp_valid) exp_ov = 1'b1;
            exp_valid = 1'b1;
            exp_data  = d;
            repeat ($urandom_range(1, 4)) tick();
            checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL rand_data got %h want %h", rx_data, exp_data); end
            checks++; if (rx_valid !== exp_valid) begin errors++; $display("FAIL rand_valid got %b want %b", rx_valid, exp_valid); end
            checks++; if (overrun !== exp_ov) begin errors++; $display("FAIL rand_overrun got %b want %b", overrun, exp_ov); end
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                checks++; if (rx_valid !== exp_valid || overrun !== exp_ov) begin errors++; $display("FAIL rand_ack got %b%b want %b%b", rx_valid, overrun, exp_valid, exp_ov); end
            end
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        rxd = 1'b1;
        tick();
        checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL b2b_data got %h want 0f", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", rx_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
        exp_valid = 1'b1;
        do_ack();
        checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_ack got %b%b want 00", rx_valid, overrun); end
    endtask

    task automatic test_frame_err();
        int v0, f0, n;
        logic ok;
        v0 = valid_rises; f0 = ferr_cycles;
        send_frame(8'h3C, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) ok = 1'b0;
            tick();
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ferr_busy_hold got %b want 1", ok); end
        checks++; if (ferr_cycles !== f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d want %0d", ferr_cycles - f0, 1); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", rx_valid); end
        rxd = 1'b1;
        n = 0;
        while (busy && n < 8) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_release got busy %b want 0", busy); end
        repeat (3 * C) tick();
        checks++; if (valid_rises !== v0 || busy !== 1'b0) begin errors++; $display("FAIL ferr_no_second got rises %0d want %0d", valid_rises, v0); end
    endtask

    task automatic test_glitch();
        int v0, f0, n;
        v0 = valid_rises; f0 = ferr_cycles;
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        n = 0;
        while (busy && n < 8) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
        repeat (2 * C) tick();
        checks++; if (valid_rises !== v0 || ferr_cycles !== f0 || busy !== 1'b0) begin errors++; $display("FAIL glitch_flags got rises %0d ferr %0d want %0d %0d", valid_rises, ferr_cycles, v0, f0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        v0 = valid_rises;
        rxd = 1'b0;
        repeat (C) tick();
        rxd = 1'b1;
        repeat (4 * C + C / 2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_abort got busy %b ferr %b want 0 0", busy, frame_err); end
        rst = 1'b1;
        repeat (4) tick();
        checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b want 00", rx_valid, overrun); end
        fork
            send_frame(8'h81, 1'b1);
            begin repeat (meas_lat - 1) tick(); rx_ack = 1'b1; tick(); rx_ack = 1'b0; end
        join
        rxd = 1'b1;
        tick();
        checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_81 got %h/%b want 81/1", rx_data, rx_valid); end
        checks++; if (overrun !== 1'b0 || valid_rises !== v0 + 1) begin errors++; $display("FAIL rstmid_once got ov %b rises %0d want 0 %0d", overrun, valid_rises, v0 + 1); end
        fork
            send_frame(8'h5A, 1'b1);
            begin repeat (meas_lat - 1) tick(); rx_ack = 1'b1; tick(); rx_ack = 1'b0; end
        join
        rxd = 1'b1;
        tick();
        checks++; if (rx_data !== 8'h5A || rx_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ack_at_load got %h/%b/%b want 5a/1/0", rx_data, rx_valid, overrun); end
        exp_valid = 1'b1;
        do_ack();
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_random();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
